// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
// State encoding, LFSR seed/taps and the LFSR step function.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Taps 8,6,5,4 in 1-based numbering -> bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mem_wait_lfsr.sv
// 8-bit Fibonacci LFSR used to jitter the response wait.
// Only instantiated when MEM_RANDOM_WAIT_EN is defined.
module mem_wait_lfsr
  import mem_resp_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  output logic [7:0] value
);

  logic [7:0] r_value;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_value <= LFSR_SEED;
    end else if (step) begin
      r_value <= lfsr_next(r_value);
    end
  end

  assign value = r_value;

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory target: one request at a time, fixed wait, 1-cycle ready.
// Optional MEM_RANDOM_WAIT_EN adds LFSR jitter (0..3) to the wait.
module data_memory_responder
  import mem_resp_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] OOR_DATA    = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memoryReq,
  input  logic [31:0] memoryAddress,
  input  logic        memoryWE,
  input  logic [31:0] memoryOut,
  output logic [31:0] memoryIn,
  output logic        memoryReady,
  output logic        memoryErr
);

  localparam int AW = $clog2(DEPTH);

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH];

  logic        w_accept;
  logic        w_to_resp;
  logic [4:0]  w_wait;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_we;
  logic        w_oor;
  logic        w_cap_oor;

  assign w_accept = (r_state == ST_IDLE) && memoryReq;

`ifdef MEM_RANDOM_WAIT_EN
  logic [7:0] w_lfsr;

  mem_wait_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (w_accept),
    .value (w_lfsr)
  );

  assign w_wait = 5'(WAIT_CYCLES) + {3'b000, w_lfsr[1:0]};
`else
  assign w_wait = 5'(WAIT_CYCLES);
`endif

  // With zero wait the response is loaded straight from the live inputs
  assign w_addr  = (r_state == ST_IDLE) ? memoryAddress : r_addr;
  assign w_wdata = (r_state == ST_IDLE) ? memoryOut     : r_wdata;
  assign w_we    = (r_state == ST_IDLE) ? memoryWE      : r_we;

  assign w_oor     = |w_addr[31:AW];
  assign w_cap_oor = |r_addr[31:AW];

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (memoryReq) begin
          w_next = (w_wait == 5'd0) ? ST_RESPOND : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 5'd0) begin
          w_next = ST_RESPOND;
        end
      end
      ST_RESPOND: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  assign w_to_resp = (w_next == ST_RESPOND) && (r_state != ST_RESPOND);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= 5'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_we    <= 1'b0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= memoryAddress;
        r_wdata <= memoryOut;
        r_we    <= memoryWE;
        r_cnt   <= (w_wait == 5'd0) ? 5'd0 : w_wait - 5'd1;
      end else if (r_state == ST_WAIT && r_cnt != 5'd0) begin
        r_cnt <= r_cnt - 5'd1;
      end
      if (w_to_resp) begin
        if (w_we) begin
          r_rdata <= w_wdata;
        end else if (w_oor) begin
          r_rdata <= OOR_DATA;
        end else begin
          r_rdata <= r_mem[w_addr[AW-1:0]];
        end
        if (w_oor) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  // Storage is never reset; the write commits as RESPOND ends
  always_ff @(posedge clk) begin
    if (!reset && r_state == ST_RESPOND && r_we && !w_cap_oor) begin
      r_mem[r_addr[AW-1:0]] <= r_wdata;
    end
  end

  assign memoryReady = (r_state == ST_RESPOND);
  assign memoryIn    = r_rdata;
  assign memoryErr   = r_err;

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder (wait 2 and wait 0 instances).
// Follows MEM_RANDOM_WAIT_EN with its own LFSR model.
module tb_data_memory_responder;

  localparam int          DEPTH = 1024;
  localparam int          WA    = 2;
  localparam int          WB    = 0;
  localparam logic [31:0] OOR_A = 32'hDEAD_BEEF;
  localparam logic [31:0] OOR_B = 32'h0;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        rst_a, req_a, we_a, rdy_a, err_a;
  logic [31:0] addr_a, wd_a, rin_a;
  logic        rst_b, req_b, we_b, rdy_b, err_b;
  logic [31:0] addr_b, wd_b, rin_b;

  exp_t        qa[$];
  exp_t        qb[$];
  exp_t        ea, eb;
  logic [31:0] mem_a [int];
  logic [31:0] mem_b [int];
  logic        errm_a, errm_b;
  logic [7:0]  lf_a, lf_b;
  logic        prev_a, prev_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_memory_responder #(
    .DEPTH(DEPTH), .WAIT_CYCLES(WA), .OOR_DATA(OOR_A)
  ) dut_a (
    .clk(clk), .reset(rst_a), .memoryReq(req_a),
    .memoryAddress(addr_a), .memoryWE(we_a), .memoryOut(wd_a),
    .memoryIn(rin_a), .memoryReady(rdy_a), .memoryErr(err_a)
  );

  data_memory_responder #(
    .DEPTH(DEPTH), .WAIT_CYCLES(WB), .OOR_DATA(OOR_B)
  ) dut_b (
    .clk(clk), .reset(rst_b), .memoryReq(req_b),
    .memoryAddress(addr_b), .memoryWE(we_b), .memoryOut(wd_b),
    .memoryIn(rin_b), .memoryReady(rdy_b), .memoryErr(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] lnext(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic int weff(input int w, input logic [7:0] l);
`ifdef MEM_RANDOM_WAIT_EN
    return w + int'(l[1:0]);
`else
    return w;
`endif
  endfunction

  always @(negedge clk) begin
    if (rdy_a) begin
      chk("a_b2b", {31'd0, prev_a}, 32'd0);
      if (qa.size() == 0) begin
        chk("a_unexp_ready", 32'd1, 32'd0);
      end else begin
        ea = qa.pop_front();
        chk("a_latency", cyc, ea.cyc);
        chk("a_data", rin_a, ea.data);
        chk("a_err", {31'd0, err_a}, {31'd0, ea.err});
      end
    end
  end

  always @(negedge clk) begin
    if (rdy_b) begin
      chk("b_b2b", {31'd0, prev_b}, 32'd0);
      if (qb.size() == 0) begin
        chk("b_unexp_ready", 32'd1, 32'd0);
      end else begin
        eb = qb.pop_front();
        chk("b_latency", cyc, eb.cyc);
        chk("b_data", rin_b, eb.data);
        chk("b_err", {31'd0, err_b}, {31'd0, eb.err});
      end
    end
  end

  always @(negedge clk) begin
    prev_a <= rdy_a;
    prev_b <= rdy_b;
  end

  function automatic exp_t model(input bit sel, input logic [31:0] ad,
                                 input logic we, input logic [31:0] wd);
    exp_t e;
    bit oor;
    oor = (ad >= 32'(DEPTH));
    if (!sel) begin
      e.cyc = cyc + 1 + weff(WA, lf_a);
      lf_a  = lnext(lf_a);
      e.data = we ? wd : (oor ? OOR_A : mem_a[int'(ad)]);
      if (we && !oor) mem_a[int'(ad)] = wd;
      if (oor) errm_a = 1'b1;
      e.err = errm_a;
    end else begin
      e.cyc = cyc + 1 + weff(WB, lf_b);
      lf_b  = lnext(lf_b);
      e.data = we ? wd : (oor ? OOR_B : mem_b[int'(ad)]);
      if (we && !oor) mem_b[int'(ad)] = wd;
      if (oor) errm_b = 1'b1;
      e.err = errm_b;
    end
    return e;
  endfunction

  task automatic drain(input bit sel);
    for (int i = 0; i < 40; i++) begin
      if ((sel ? qb.size() : qa.size()) == 0) break;
      @(negedge clk);
    end
    if (!sel && qa.size() != 0) begin
      chk("a_timeout", qa.size(), 0);
      qa.delete();
    end
    if (sel && qb.size() != 0) begin
      chk("b_timeout", qb.size(), 0);
      qb.delete();
    end
  endtask

  task automatic issue(input bit sel, input logic [31:0] ad,
                       input logic we, input logic [31:0] wd);
    @(negedge clk);
    if (!sel) begin
      req_a = 1'b1; addr_a = ad; we_a = we; wd_a = wd;
      qa.push_back(model(0, ad, we, wd));
    end else begin
      req_b = 1'b1; addr_b = ad; we_b = we; wd_b = wd;
      qb.push_back(model(1, ad, we, wd));
    end
    @(negedge clk);
    req_a = 1'b0;
    req_b = 1'b0;
    addr_a = 32'hFFFF_FFFF; wd_a = 32'h5A5A_5A5A; we_a = ~we_a;
    addr_b = 32'hFFFF_FFFF; wd_b = 32'h5A5A_5A5A; we_b = ~we_b;
    drain(sel);
  endtask

  task automatic reset_a();
    @(negedge clk);
    rst_a = 1'b1;
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    lf_a = 8'hA5;
    errm_a = 1'b0;
    chk("a_rst_ready", {31'd0, rdy_a}, 32'd0);
    chk("a_rst_in", rin_a, 32'd0);
    chk("a_rst_err", {31'd0, err_a}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nf;
    logic [31:0] ra, rd;
    rst_a = 1'b1; rst_b = 1'b1;
    req_a = 1'b0; req_b = 1'b0;
    we_a = 1'b0; we_b = 1'b0;
    addr_a = '0; addr_b = '0; wd_a = '0; wd_b = '0;
    lf_a = 8'hA5; lf_b = 8'hA5;
    errm_a = 1'b0; errm_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    chk("a_rst_ready", {31'd0, rdy_a}, 32'd0);
    chk("a_rst_in", rin_a, 32'd0);
    chk("a_rst_err", {31'd0, err_a}, 32'd0);
    chk("b_rst_ready", {31'd0, rdy_b}, 32'd0);
    chk("b_rst_in", rin_b, 32'd0);
    chk("b_rst_err", {31'd0, err_b}, 32'd0);

    issue(0, 32'd5, 1'b1, 32'hCAFE_F00D);
    issue(0, 32'd5, 1'b0, 32'h0);
    issue(0, 32'd0, 1'b1, 32'h0BAD_C0DE);
    issue(0, 32'd7, 1'b1, 32'h0000_0011);

    issue(0, 32'd1024, 1'b1, 32'h0000_1234);
    repeat (3) @(negedge clk);
    chk("a_err_sticky", {31'd0, err_a}, 32'd1);
    issue(0, 32'd1024, 1'b0, 32'h0);
    issue(0, 32'd0, 1'b0, 32'h0);
    issue(0, 32'h8000_0005, 1'b0, 32'h0);
    issue(0, 32'd5, 1'b0, 32'h0);

    @(negedge clk);
    req_a = 1'b1; addr_a = 32'd7; we_a = 1'b1; wd_a = 32'hFFFF_0000;
    @(negedge clk);
    req_a = 1'b0;
    reset_a();
    repeat (3) @(negedge clk);
    issue(0, 32'd7, 1'b0, 32'h0);
    issue(0, 32'd1023, 1'b1, 32'h7777_1023);
    issue(0, 32'd1023, 1'b0, 32'h0);

    for (int i = 0; i < 6; i++) begin
      issue(1, 32'(i), 1'b1, 32'h100 + 32'(i));
    end
    nf = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      req_b = 1'b1; addr_b = 32'(k); we_b = 1'b0;
      if (k >= nf) begin
        nf = k + weff(WB, lf_b) + 2;
        qb.push_back(model(1, 32'(k), 1'b0, 32'h0));
      end
    end
    @(negedge clk);
    req_b = 1'b0;
    drain(1);

    for (int i = 0; i < 6; i++) begin
      ra = 32'($urandom_range(0, DEPTH - 1));
      rd = $urandom;
      issue(0, ra, 1'b1, rd);
      issue(0, ra, 1'b0, 32'h0);
    end

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
